ram_sp_arb: RTL and testbench

//  Parametrised single-port embedded RAM for the 6502 system, with a second

---
 rtl/ram_sp_arb_pkg.sv | 12 +
 rtl/ram_sp_arb_if.sv | 33 +++
 rtl/ram_sp_core.sv | 20 ++
 rtl/ram_sp_arb.sv | 147 ++++++++++++++
 tb/tb_ram_sp_arb.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_sp_arb_pkg.sv
// ram_sp_arb shared types: FSM state encoding for the arbitrated RAM.
// No ports; imported by the top level.
package ram_sp_arb_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2,
    S_REL   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_sp_arb_if.sv
// ram_sp_arb bus: CPU port, write-protect, host 4-phase handshake, busy.
// master = CPU/host side, slave = RAM side.
interface ram_sp_arb_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_en;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              wp_en;
  logic              wp_fault;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_ack;
  logic [DATA_W-1:0] host_dout;
  logic              busy;

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_din, wp_en,
    output host_req, host_we, host_addr, host_din,
    input  cpu_dout, wp_fault, host_ack, host_dout, busy
  );

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_din, wp_en,
    input  host_req, host_we, host_addr, host_din,
    output cpu_dout, wp_fault, host_ack, host_dout, busy
  );
endinterface

// File: rtl/ram_sp_core.sv
// Bare single-port array, registered read-first output, no reset.
// Ports: clk, we, addr, din, dout.
module ram_sp_core #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= din;
    dout <= r_mem[addr];
  end
endmodule

// File: rtl/ram_sp_arb.sv
// Single-port RAM with CPU/host arbitration, post-reset fill, CPU write window.
// Ports: clk, reset (sync, active-high), bus (ram_sp_arb_if.slave).
module ram_sp_arb
  import ram_sp_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 15,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       DEPTH     = 32768,
  parameter bit                CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int unsigned       WP_BASE   = 'h7F00,
  parameter int unsigned       WP_TOP    = 'h7FFF
) (
  input logic         clk,
  input logic         reset,
  ram_sp_arb_if.slave bus
);
  localparam int unsigned IDX_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_clr;
  logic              r_busy;
  logic              r_ack;
  logic              r_fault;
  logic              r_cpu_rd;
  logic              r_host_rd;
  logic              r_oor;
  logic [DATA_W-1:0] r_cpu_dout;
  logic [DATA_W-1:0] r_host_dout;

  logic              w_clr;
  logic              w_cpu_go;
  logic              w_grant;
  logic              w_cpu_rng;
  logic              w_host_rng;
  logic              w_cpu_wp;
  logic              w_we;
  logic              w_oor;
  logic [IDX_W-1:0]  w_addr;
  logic [DATA_W-1:0] w_din;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] w_rd;

  assign w_clr      = (r_state == S_CLEAR);
  assign w_cpu_go   = !w_clr && bus.cpu_en;
  assign w_grant    = (r_state == S_IDLE) && bus.host_req
                   && !bus.cpu_en;
  assign w_cpu_rng  = 32'(bus.cpu_addr) < DEPTH;
  assign w_host_rng = 32'(bus.host_addr) < DEPTH;
  assign w_cpu_wp   = bus.wp_en
                   && 32'(bus.cpu_addr) >= WP_BASE
                   && 32'(bus.cpu_addr) <= WP_TOP;

  // One physical port: clear, then CPU, then host.
  always_comb begin
    w_we   = 1'b0;
    w_addr = bus.cpu_addr[IDX_W-1:0];
    w_din  = bus.cpu_din;
    w_oor  = !w_cpu_rng;
    unique case (1'b1)
      w_clr: begin
        w_we   = 1'b1;
        w_addr = r_clr;
        w_din  = CLEAR_VAL;
      end
      w_cpu_go: begin
        w_we = bus.cpu_we && w_cpu_rng && !w_cpu_wp;
      end
      w_grant: begin
        w_we   = bus.host_we && w_host_rng;
        w_addr = bus.host_addr[IDX_W-1:0];
        w_din  = bus.host_din;
        w_oor  = !w_host_rng;
      end
      default: ;
    endcase
    if (reset) w_we = 1'b0;
  end

  ram_sp_core #(
    .ADDR_W (IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk  (clk),
    .we   (w_we),
    .addr (w_addr),
    .din  (w_din),
    .dout (w_q)
  );

  // Out-of-range reads are masked to zero after the array read.
  assign w_rd = r_oor ? '0 : w_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CLEAR_EN ? S_CLEAR : S_IDLE;
      r_busy      <= CLEAR_EN;
      r_clr       <= '0;
      r_ack       <= 1'b0;
      r_fault     <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_host_rd   <= 1'b0;
      r_oor       <= 1'b0;
      r_cpu_dout  <= '0;
      r_host_dout <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_cpu_rd  <= w_cpu_go && !bus.cpu_we;
      r_host_rd <= w_grant && !bus.host_we;
      r_oor     <= w_oor;
      if (r_cpu_rd)  r_cpu_dout  <= w_rd;
      if (r_host_rd) r_host_dout <= w_rd;
      if (w_cpu_go && bus.cpu_we && w_cpu_wp)
        r_fault <= 1'b1;
      unique case (r_state)
        S_CLEAR: begin
          r_clr <= r_clr + IDX_W'(1);
          if (r_clr == LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
          end
        end
        S_ACK: r_state <= S_REL;
        S_REL: begin
          if (!bus.host_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Hold registers keep the last read; fresh data bypasses for one cycle.
  assign bus.cpu_dout  = r_cpu_rd ? w_rd : r_cpu_dout;
  assign bus.host_dout = r_host_rd ? w_rd : r_host_dout;
  assign bus.host_ack  = r_ack;
  assign bus.wp_fault  = r_fault;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ram_sp_arb.sv
// Scoreboard bench for ram_sp_arb: random CPU/host traffic vs array model.
// Driver pushes expectations at negedge; monitor checks after posedge.
module tb_ram_sp_arb;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8192;
  localparam int unsigned IW    = 13;
  localparam int unsigned WPB   = 'h1F00;
  localparam int unsigned WPT   = 'h1FFF;
  localparam logic [7:0]  CV    = 8'hE5;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
  } chk_t;

  typedef struct {
    int         due;
    bit         rd;
    logic [7:0] exp;
  } hchk_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  chk_t  sq[$];
  hchk_t hq[$];

  logic [7:0] mem_m [DEPTH];
  int         m_clr;
  int         m_hph;
  logic       m_fault;
  logic [7:0] m_dout;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [7:0]    h_din;

  ram_sp_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_sp_arb #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .CLEAR_EN  (1'b1),
    .CLEAR_VAL (CV),
    .WP_BASE   (WPB),
    .WP_TOP    (WPT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rd(input logic [AW-1:0] a);
    return (a < DEPTH) ? mem_m[a[IW-1:0]] : 8'h00;
  endfunction

  function automatic bit inwin(input logic [AW-1:0] a);
    return (32'(a) >= WPB) && (32'(a) <= WPT);
  endfunction

  function automatic logic [AW-1:0] raddr();
    case ($urandom_range(0, 3))
      0: return AW'($urandom_range(0, 31));
      1: return AW'($urandom_range(WPB - 2, WPB + 2));
      2: return AW'($urandom_range(DEPTH - 4, DEPTH + 3));
      default: return AW'($urandom_range(0, 32767));
    endcase
  endfunction

  task automatic push(input int kind, input logic [7:0] e);
    sq.push_back('{cyc + 1, kind, e});
  endtask

  // Applies the next clock edge to the model, then waits for it.
  task automatic step(input logic ce, input logic cw,
                      input logic [AW-1:0] ca,
                      input logic [7:0] cd, input logic wp);
    bus.cpu_en    = ce;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_din   = cd;
    bus.wp_en     = wp;
    bus.host_req  = h_req;
    bus.host_we   = h_we;
    bus.host_addr = h_addr;
    bus.host_din  = h_din;
    if (m_clr > 0) begin
      if (ce && !cw) push(0, m_dout);
      m_clr--;
      if (m_clr == 0)
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = CV;
    end else begin
      if (ce && !cw) begin
        m_dout = rd(ca);
        push(0, m_dout);
      end
      if (ce && cw) begin
        if (wp && inwin(ca)) m_fault = 1'b1;
        else if (ca < DEPTH) mem_m[ca[IW-1:0]] = cd;
      end
      case (m_hph)
        0: if (h_req && !ce) begin
          hq.push_back('{cyc + 1, !h_we, rd(h_addr)});
          if (h_we && h_addr < DEPTH)
            mem_m[h_addr[IW-1:0]] = h_din;
          m_hph = 1;
        end
        1: m_hph = 2;
        default: if (!h_req) m_hph = 0;
      endcase
    end
    push(1, {7'd0, m_clr > 0});
    push(2, {7'd0, m_fault});
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 8'h00, 1'b0);
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a,
                        input logic [7:0] d, input logic wp);
    step(1'b1, 1'b1, a, d, wp);
  endtask

  task automatic do_reset();
    sq.delete();
    hq.delete();
    h_req = 1'b0;
    reset = 1'b1;
    bus.cpu_en   = 1'b0;
    bus.host_req = 1'b0;
    m_clr   = DEPTH;
    m_hph   = 0;
    m_fault = 1'b0;
    m_dout  = 8'h00;
    push(0, 8'h00);
    push(1, 8'h01);
    push(2, 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 16; i++) begin
      if (h_req && m_hph == 2) h_req = 1'b0;
      if (!h_req && m_hph == 0) break;
      idle();
    end
  endtask

  task automatic rand_cycles(input int n, input bit hen);
    for (int i = 0; i < n; i++) begin
      if (hen) begin
        if (!h_req) begin
          if (m_hph == 0 && $urandom_range(0, 3) == 0) begin
            h_req  = 1'b1;
            h_we   = 1'($urandom_range(0, 1));
            h_addr = raddr();
            h_din  = 8'($urandom);
          end
        end else if (m_hph == 2 && $urandom_range(0, 2) == 0) begin
          h_req = 1'b0;
        end
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           raddr(), 8'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    chk_t  e;
    hchk_t h;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sq.size() > 0 && sq[0].due <= cyc) begin
        e = sq.pop_front();
        case (e.kind)
          0: check("cpu_dout", {24'd0, bus.cpu_dout}, {24'd0, e.exp});
          1: check("busy", {31'd0, bus.busy}, {24'd0, e.exp});
          default:
            check("wp_fault", {31'd0, bus.wp_fault}, {24'd0, e.exp});
        endcase
      end
      if (hq.size() > 0 && hq[0].due <= cyc) begin
        h = hq.pop_front();
        check("host_ack", {31'd0, bus.host_ack}, 32'd1);
        if (h.rd)
          check("host_dout", {24'd0, bus.host_dout}, {24'd0, h.exp});
      end else begin
        check("host_ack_idle", {31'd0, bus.host_ack}, 32'd0);
      end
    end
  end

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    h_req = 1'b0;
    h_we  = 1'b0;
    h_addr = '0;
    h_din  = 8'h00;
    bus.cpu_en    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_din   = 8'h00;
    bus.wp_en     = 1'b0;
    bus.host_req  = 1'b0;
    bus.host_we   = 1'b0;
    bus.host_addr = '0;
    bus.host_din  = 8'h00;
    @(negedge clk);

    do_reset();
    cpu_wr(AW'('h0010), 8'hAA, 1'b0);
    cpu_rd(AW'('h0010));
    rand_cycles(int'(DEPTH) - 5, 1'b0);
    h_req  = 1'b1;
    h_we   = 1'b0;
    h_addr = AW'('h0011);
    repeat (6) idle();
    settle();
    cpu_rd(AW'('h1234));
    cpu_rd(AW'('h0010));

    cpu_wr(AW'(WPB), 8'h55, 1'b1);
    cpu_rd(AW'(WPB));
    h_req  = 1'b1;
    h_we   = 1'b1;
    h_addr = AW'(WPB);
    h_din  = 8'h55;
    idle();
    settle();
    cpu_rd(AW'(WPB));
    cpu_wr(AW'(WPT), 8'h66, 1'b0);
    cpu_rd(AW'(WPT));
    cpu_wr(AW'(WPB - 1), 8'h67, 1'b1);
    cpu_rd(AW'(WPB - 1));

    cpu_wr(AW'('h0200), 8'h3C, 1'b0);
    h_req  = 1'b1;
    h_we   = 1'b0;
    h_addr = AW'('h0200);
    for (int i = 0; i < 5; i++) cpu_rd(AW'(i));
    repeat (6) idle();
    h_req = 1'b0;
    repeat (3) idle();

    cpu_wr(AW'('h0100), 8'h12, 1'b0);
    cpu_rd(AW'('h0100));
    cpu_rd(AW'(DEPTH));
    cpu_rd(AW'('h7F00));
    cpu_wr(AW'(DEPTH + 5), 8'h77, 1'b0);
    cpu_rd(AW'(5));
    cpu_wr(AW'(DEPTH - 1), 8'h9A, 1'b0);
    cpu_rd(AW'(DEPTH - 1));

    rand_cycles(3000, 1'b1);
    settle();

    do_reset();
    rand_cycles(int'(DEPTH) / 2, 1'b0);
    do_reset();
    rand_cycles(int'(DEPTH) + 2, 1'b0);
    cpu_rd(AW'('h0100));
    cpu_rd(AW'(DEPTH - 1));
    rand_cycles(200, 1'b1);
    settle();
    repeat (3) idle();

    check("sq_drained", 32'(sq.size()), 32'd0);
    check("hq_drained", 32'(hq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
